// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive-side byte FIFO behind a UART receiver; one write per
//            rx_en rising edge, registered read port, sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_en,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    localparam logic [ADDR_W:0]   c_depth   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_rx_en_d;

    logic              w_wr_req;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_drop;
    logic [ADDR_W:0]   w_count_nxt;

    // A full FIFO can still take a byte when a read frees a slot this cycle.
    assign w_wr_req = rx_en & ~r_rx_en_d;
    assign w_rd_acc = rd_en & ~r_empty;
    assign w_wr_acc = w_wr_req & (~r_full | w_rd_acc);
    assign w_drop   = w_wr_req & r_full & ~w_rd_acc;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + c_cnt_one;
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - c_cnt_one;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            // Held high so a level already present at reset release is ignored.
            r_rx_en_d  <= 1'b1;
        end else begin
            r_rx_en_d  <= rx_en;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
            end
            r_rd_valid <= w_rd_acc;
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == c_depth);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign empty    = r_empty;
    assign full     = r_full;
    assign count    = r_count;
    assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rx_data;
    logic              rx_en;
    logic              rd_en;
    logic              clr_ovf;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_en    (rx_en),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus the externally visible flags.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rd_valid;
    logic              m_ovf;
    logic              m_prev_en;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic step(input logic en, input logic [DATA_W-1:0] d,
                        input logic rd, input logic clr, input logic rstn);
        int  sz;
        logic wr_req, rd_acc, wr_ok;
        rx_en   = en;
        rx_data = d;
        rd_en   = rd;
        clr_ovf = clr;
        rst_n   = rstn;
        if (!rstn) begin
            m_q.delete();
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
            m_ovf      = 1'b0;
            m_prev_en  = 1'b1;
        end else begin
            sz     = m_q.size();
            wr_req = en && !m_prev_en;
            rd_acc = rd && (sz > 0);
            wr_ok  = wr_req && ((sz < DEPTH) || rd_acc);
            m_rd_valid = rd_acc;
            if (rd_acc) m_rd_data = m_q.pop_front();
            if (wr_ok) m_q.push_back(d);
            if (wr_req && !wr_ok) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            m_prev_en = en;
        end
        @(negedge clk);
        chk("count",    32'(count),    32'(m_q.size()));
        chk("empty",    32'(empty),    32'(m_q.size() == 0));
        chk("full",     32'(full),     32'(m_q.size() == DEPTH));
        chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        chk("rd_data",  32'(rd_data),  32'(m_rd_data));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic pulse_byte(input logic [DATA_W-1:0] d, input int hold);
        for (int i = 0; i < hold; i++) step(1'b1, d, 1'b0, 1'b0, 1'b1);
        step(1'b0, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic en_r;
        logic [DATA_W-1:0] d_r;
        int rd_pct;

        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Single long rx_en period yields one byte.
        pulse_byte(8'h55, 325);
        read_n(1);
        chk("single_byte", 32'(rd_data), 32'h55);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill, drop one, drain in order.
        for (int i = 0; i < DEPTH; i++) pulse_byte(8'(i), 2 + (i % 3));
        pulse_byte(8'hAA, 3);
        chk("ovf_after_drop", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("drain_order", 32'(rd_data), 32'(i));
        end
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Write and read in the same cycle while full.
        for (int i = 0; i < DEPTH; i++) pulse_byte(8'(8'h30 + i), 1);
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("full_rw_count", 32'(count), 32'(DEPTH));
        step(1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        read_n(DEPTH);
        chk("full_rw_last", 32'(rd_data), 32'h77);

        // Empty read, then interleaved traffic across pointer wraps.
        read_n(2);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b1);
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
            chk("wrap_order", 32'(rd_data), 32'(8'h80 + i));
        end

        // Overflow clear, and drop coinciding with clear.
        for (int i = 0; i < DEPTH + 1; i++) pulse_byte(8'(i), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        read_n(DEPTH);

        // Reset with bytes queued and rx_en held high.
        for (int i = 0; i < 3; i++) pulse_byte(8'(8'hC0 + i), 2);
        step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hD0, 1'b0, 1'b0, 1'b1);
        chk("rst_no_write", 32'(count), 32'd0);
        pulse_byte(8'hD1, 0);
        pulse_byte(8'hD2, 2);
        read_n(1);
        chk("rst_next_edge", 32'(rd_data), 32'hD2);

        // Randomized traffic with phases biased toward filling or draining.
        en_r = 1'b0;
        d_r  = '0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rd_pct = $urandom_range(10, 90);
            if ($urandom_range(0, 2) == 0) begin
                en_r = ~en_r;
                if (en_r) d_r = 8'($urandom);
            end
            step(en_r, d_r, ($urandom_range(0, 99) < rd_pct),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 299) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
